// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, slot field layout, opcodes and fetch-path types.
// Used by the fetch stage, its skid buffer and the fetch/decode interface.
package cpu_pkg;

    localparam int PC_W     = 16;
    localparam int INSTR_W  = 22;
    localparam int BUNDLE_W = 4 * INSTR_W;
    localparam int N_SLOTS  = 4;

    // Slot instruction field offsets
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int R0_LSB   = 5;
    localparam int R0_MSB   = 9;
    localparam int R1_LSB   = 10;
    localparam int R1_MSB   = 14;
    localparam int RD_LSB   = 15;
    localparam int RD_MSB   = 19;
    localparam int COND_LSB = 20;
    localparam int COND_MSB = 21;

    localparam logic [4:0] OP_JMP  = 5'b01001;
    localparam logic [4:0] HALT_OP = 5'b11111;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef logic [PC_W-1:0]     pc_t;
    typedef logic [INSTR_W-1:0]  instr_t;
    typedef logic [BUNDLE_W-1:0] bundle_t;

    // Slot position inside a bundle {A0,A1,M,LS}; LS occupies the low bits.
    typedef enum logic [1:0] {
        SLOT_LS = 2'd0,
        SLOT_M  = 2'd1,
        SLOT_A1 = 2'd2,
        SLOT_A0 = 2'd3
    } slot_e;

    typedef struct packed {
        bundle_t bundle;
        pc_t     pc;
    } fetch_entry_t;

    function automatic logic [4:0] slot_opcode(input instr_t instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_bundle_unit_if.sv
// Fetch stage bus: decode-side control, instruction memory port and the IF/ID register.
// master = fetch unit, slave = the surrounding pipeline/memory.
interface fetch_bundle_unit_if;
    import cpu_pkg::*;

    logic    stall;
    logic    predRW;
    pc_t     jmp_target;

    pc_t     imem_addr;
    logic    imem_rd_en;
    bundle_t imem_data;

    instr_t  A0;
    instr_t  A1;
    instr_t  M;
    instr_t  LS;
    logic    bundle_valid;
    pc_t     bundle_pc;
    logic    halted;

    modport master (
        input  stall, predRW, jmp_target, imem_data,
        output imem_addr, imem_rd_en,
        output A0, A1, M, LS, bundle_valid, bundle_pc, halted
    );

    modport slave (
        output stall, predRW, jmp_target, imem_data,
        input  imem_addr, imem_rd_en,
        input  A0, A1, M, LS, bundle_valid, bundle_pc, halted
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a returned bundle and its address while decode stalls.
// Clear wins over load; the payload is only meaningful while o_valid is set.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  logic    i_clear,
    input  bundle_t i_bundle,
    input  pc_t     i_pc,
    output logic    o_valid,
    output bundle_t o_bundle,
    output pc_t     o_pc
);

    logic         r_valid;
    fetch_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load && !i_clear) begin
            r_entry <= '{bundle: i_bundle, pc: i_pc};
        end
    end

    assign o_valid  = r_valid;
    assign o_bundle = r_entry.bundle;
    assign o_pc     = r_entry.pc;

endmodule

// File: rtl/fetch_bundle_unit.sv
// VLIW instruction fetch: drives the synchronous instruction memory, captures bundles into
// IF/ID, absorbs decode stalls with a skid entry, redirects on mispredict and stops on HALT.
module fetch_bundle_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
)
(
    input  logic                 clk,
    input  logic                 rst,
    fetch_bundle_unit_if.master  bus
);

    // Fetch state
    pc_t     r_fetch_pc;
    logic    r_inflight_v;
    pc_t     r_inflight_pc;
    logic    r_halted;

    // IF/ID register
    logic    r_bundle_valid;
    pc_t     r_bundle_pc;
    instr_t  w_slot_q   [N_SLOTS];
    instr_t  w_src_slot [N_SLOTS];

    // Skid buffer
    logic    w_skid_v;
    bundle_t w_skid_bundle;
    pc_t     w_skid_pc;
    logic    w_skid_load;
    logic    w_skid_clear;

    // Source select and read request
    logic    w_src_v;
    bundle_t w_src_bundle;
    pc_t     w_src_pc;
    logic    w_src_halt;
    logic    w_run;
    logic    w_rd_en;
    pc_t     w_rd_addr;

    assign w_run = !bus.predRW && !bus.stall;

    // A held skid entry is always older than anything arriving from memory.
    always_comb begin
        w_src_v      = 1'b0;
        w_src_bundle = bus.imem_data;
        w_src_pc     = r_inflight_pc;
        if (w_skid_v) begin
            w_src_v      = 1'b1;
            w_src_bundle = w_skid_bundle;
            w_src_pc     = w_skid_pc;
        end else if (r_inflight_v) begin
            w_src_v      = 1'b1;
        end
    end

    assign w_src_halt = w_src_v && (slot_opcode(w_src_slot[SLOT_A0]) == HALT_OP);

    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_fetch_pc;
        if (rst) begin
            w_rd_en = 1'b0;
        end else if (bus.predRW) begin
            w_rd_en   = 1'b1;
            w_rd_addr = bus.jmp_target;
        end else if (!bus.stall && !r_halted && !w_src_halt) begin
            w_rd_en   = 1'b1;
        end
    end

    assign bus.imem_addr  = w_rd_addr;
    assign bus.imem_rd_en = w_rd_en;

    // Capture the returning bundle only if nothing is parked yet; a parked entry
    // implies no read was issued, so the skid can never overflow.
    assign w_skid_load  = !bus.predRW && bus.stall && r_inflight_v && !w_skid_v;
    assign w_skid_clear = !bus.stall || bus.predRW;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_clear  (w_skid_clear),
        .i_bundle (bus.imem_data),
        .i_pc     (r_inflight_pc),
        .o_valid  (w_skid_v),
        .o_bundle (w_skid_bundle),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
            r_halted      <= 1'b0;
        end else if (bus.predRW) begin
            r_fetch_pc    <= bus.jmp_target + 1'b1;
            r_inflight_v  <= 1'b1;
            r_inflight_pc <= bus.jmp_target;
            r_halted      <= 1'b0;
        end else if (bus.stall) begin
            r_inflight_v  <= 1'b0;
        end else begin
            r_halted      <= r_halted | w_src_halt;
            if (w_rd_en) begin
                r_fetch_pc    <= r_fetch_pc + 1'b1;
                r_inflight_v  <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight_v  <= 1'b0;
            end
        end
    end

    // bundle_pc keeps its last value across bubbles; it is only meaningful when valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bundle_valid <= 1'b0;
            r_bundle_pc    <= '0;
        end else if (bus.predRW) begin
            r_bundle_valid <= 1'b0;
        end else if (w_run) begin
            r_bundle_valid <= w_src_v;
            if (w_src_v) begin
                r_bundle_pc <= w_src_pc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            instr_t r_slot;

            assign w_src_slot[gi] = w_src_bundle[gi*INSTR_W +: INSTR_W];

            always_ff @(posedge clk) begin
                if (rst || bus.predRW) begin
                    r_slot <= NOP_INSTR;
                end else if (w_run) begin
                    r_slot <= w_src_v ? w_src_slot[gi] : NOP_INSTR;
                end
            end

            assign w_slot_q[gi] = r_slot;
        end
    endgenerate

    assign bus.A0           = w_slot_q[SLOT_A0];
    assign bus.A1           = w_slot_q[SLOT_A1];
    assign bus.M            = w_slot_q[SLOT_M];
    assign bus.LS           = w_slot_q[SLOT_LS];
    assign bus.bundle_valid = r_bundle_valid;
    assign bus.bundle_pc    = r_bundle_pc;
    assign bus.halted       = r_halted;

endmodule

// File: tb/tb_fetch_bundle_unit.sv
// Bench for fetch_bundle_unit: directed vector table, wrap-around instance, mid-stream reset
// and a randomized run compared against a queue-based model of the fetch stage.
module tb_fetch_bundle_unit;
    import cpu_pkg::*;

    localparam logic [15:0] HALT_ADDR = 16'h0009;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_bundle_unit_if bus0 ();
    fetch_bundle_unit_if bus1 ();

    fetch_bundle_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    fetch_bundle_unit #(.RESET_PC(16'hFFFE)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    // Memory image: every slot carries its bundle address; only HALT_ADDR holds a HALT in A0.
    function automatic logic [87:0] mem_word(input logic [15:0] a);
        logic [21:0] a0;
        a0 = (a == HALT_ADDR) ? {a, 6'b011111} : {a, 6'b000001};
        return {a0, 6'h11, a, 6'h22, a, 6'h33, a};
    endfunction

    function automatic logic [21:0] exp_a0(input logic [15:0] a);
        logic [87:0] w;
        w = mem_word(a);
        return w[87:66];
    endfunction

    function automatic logic [87:0] garbage();
        logic [95:0] g;
        g = {$urandom(), $urandom(), $urandom()};
        return g[87:0];
    endfunction

    always @(posedge clk) begin
        bus0.imem_data <= bus0.imem_rd_en ? mem_word(bus0.imem_addr) : garbage();
        bus1.imem_data <= bus1.imem_rd_en ? mem_word(bus1.imem_addr) : garbage();
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic        stall;
        logic        pred;
        logic [15:0] tgt;
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic        exp_v;
        logic [15:0] exp_pc;
        logic        exp_h;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic pr, input logic [15:0] tg,
                                input logic rd, input logic [15:0] ad,
                                input logic v, input logic [15:0] pc, input logic h);
        vec_t r;
        r = '{stall: st, pred: pr, tgt: tg, exp_rd: rd, exp_addr: ad,
              exp_v: v, exp_pc: pc, exp_h: h};
        return r;
    endfunction

    localparam int N_VEC = 25;
    vec_t tbl [N_VEC];

    // Random-phase model state: at most one fetched-but-undelivered bundle address.
    logic [15:0] m_next;
    logic [15:0] pend [$];
    logic        m_v;
    logic [15:0] m_pc;
    logic        m_h;

    initial begin
        //            st pr tgt     rd addr    v pc      h
        tbl[0]  = mk(0, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 0);
        tbl[1]  = mk(0, 0, 16'h0, 1, 16'h0001, 1, 16'h0000, 0);
        tbl[2]  = mk(0, 0, 16'h0, 1, 16'h0002, 1, 16'h0001, 0);
        tbl[3]  = mk(0, 0, 16'h0, 1, 16'h0003, 1, 16'h0002, 0);
        tbl[4]  = mk(0, 0, 16'h0, 1, 16'h0004, 1, 16'h0003, 0);
        tbl[5]  = mk(1, 0, 16'h0, 0, 16'h0000, 1, 16'h0003, 0);
        tbl[6]  = mk(1, 0, 16'h0, 0, 16'h0000, 1, 16'h0003, 0);
        tbl[7]  = mk(1, 0, 16'h0, 0, 16'h0000, 1, 16'h0003, 0);
        tbl[8]  = mk(0, 0, 16'h0, 1, 16'h0005, 1, 16'h0004, 0);
        tbl[9]  = mk(0, 0, 16'h0, 1, 16'h0006, 1, 16'h0005, 0);
        tbl[10] = mk(0, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000, 0);
        tbl[11] = mk(0, 0, 16'h0, 1, 16'h0041, 1, 16'h0040, 0);
        tbl[12] = mk(0, 0, 16'h0, 1, 16'h0042, 1, 16'h0041, 0);
        tbl[13] = mk(1, 0, 16'h0, 0, 16'h0000, 1, 16'h0041, 0);
        tbl[14] = mk(1, 1, 16'h0005, 1, 16'h0005, 0, 16'h0000, 0);
        tbl[15] = mk(0, 0, 16'h0, 1, 16'h0006, 1, 16'h0005, 0);
        tbl[16] = mk(0, 0, 16'h0, 1, 16'h0007, 1, 16'h0006, 0);
        tbl[17] = mk(0, 0, 16'h0, 1, 16'h0008, 1, 16'h0007, 0);
        tbl[18] = mk(0, 0, 16'h0, 1, 16'h0009, 1, 16'h0008, 0);
        tbl[19] = mk(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0009, 1);
        tbl[20] = mk(0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);
        tbl[21] = mk(0, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);
        tbl[22] = mk(0, 1, 16'h0002, 1, 16'h0002, 0, 16'h0000, 0);
        tbl[23] = mk(0, 0, 16'h0, 1, 16'h0003, 1, 16'h0002, 0);
        tbl[24] = mk(0, 0, 16'h0, 1, 16'h0004, 1, 16'h0003, 0);

        bus0.stall = 1'b0; bus0.predRW = 1'b0; bus0.jmp_target = '0;
        bus1.stall = 1'b0; bus1.predRW = 1'b0; bus1.jmp_target = '0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid",  bus0.bundle_valid, 1'b0);
        chk("reset_pc",     bus0.bundle_pc,    16'h0000);
        chk("reset_halted", bus0.halted,       1'b0);
        chk("reset_A0",     bus0.A0,           NOP_INSTR);
        chk("reset_LS",     bus0.LS,           NOP_INSTR);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: startup, stall/skid, redirect, redirect+stall, HALT, restart
        for (int i = 0; i < N_VEC; i++) begin
            if (i != 0) @(negedge clk);
            bus0.stall      = tbl[i].stall;
            bus0.predRW     = tbl[i].pred;
            bus0.jmp_target = tbl[i].tgt;
            #1;
            chk($sformatf("vec%0d_rd_en", i), bus0.imem_rd_en, tbl[i].exp_rd);
            if (tbl[i].exp_rd)
                chk($sformatf("vec%0d_addr", i), bus0.imem_addr, tbl[i].exp_addr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), bus0.bundle_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                chk($sformatf("vec%0d_pc", i), bus0.bundle_pc, tbl[i].exp_pc);
                chk($sformatf("vec%0d_A0", i), bus0.A0, exp_a0(tbl[i].exp_pc));
            end
            chk($sformatf("vec%0d_halted", i), bus0.halted, tbl[i].exp_h);
            if (i >= 1 && i <= 4) begin
                chk($sformatf("wrap%0d_valid", i), bus1.bundle_valid, 1'b1);
                chk($sformatf("wrap%0d_pc", i), bus1.bundle_pc, 16'(16'hFFFE + i - 1));
            end
            $display("vec %0d: stall=%0b pred=%0b rd=%0b addr=%h valid=%0b pc=%h halted=%0b",
                     i, tbl[i].stall, tbl[i].pred, bus0.imem_rd_en, bus0.imem_addr,
                     bus0.bundle_valid, bus0.bundle_pc, bus0.halted);
        end

        // Mid-stream reset while a stall is also asserted
        @(negedge clk);
        rst = 1'b1; bus0.stall = 1'b1; bus0.predRW = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valid",  bus0.bundle_valid, 1'b0);
        chk("midrst_pc",     bus0.bundle_pc,    16'h0000);
        chk("midrst_halted", bus0.halted,       1'b0);
        chk("midrst_A1",     bus0.A1,           NOP_INSTR);
        chk("midrst_M",      bus0.M,            NOP_INSTR);
        @(negedge clk);
        rst = 1'b0; bus0.stall = 1'b0;
        #1;
        chk("midrst_rd_en", bus0.imem_rd_en, 1'b1);
        chk("midrst_addr",  bus0.imem_addr,  16'h0000);
        $display("midrst: rd=%0b addr=%h", bus0.imem_rd_en, bus0.imem_addr);

        // Randomized run from the state just after reset release
        m_next = 16'h0000; pend.delete(); m_v = 1'b0; m_pc = '0; m_h = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic        st, pr, erd, dh;
            logic [15:0] tg, ea, d;
            if (c != 0) @(negedge clk);
            st = ($urandom_range(0, 9) < 3);
            pr = ($urandom_range(0, 9) == 0);
            tg = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 15));
            bus0.stall = st; bus0.predRW = pr; bus0.jmp_target = tg;
            #1;
            erd = 1'b0; ea = '0; dh = 1'b0;
            if (pr) begin
                erd = 1'b1; ea = tg;
                pend.delete(); pend.push_back(tg);
                m_next = tg + 16'd1; m_h = 1'b0; m_v = 1'b0;
            end else if (!st) begin
                if (pend.size() > 0) begin
                    d = pend.pop_front();
                    m_v = 1'b1; m_pc = d; dh = (d == HALT_ADDR);
                end else begin
                    m_v = 1'b0;
                end
                erd = !m_h && !dh;
                if (erd) begin
                    ea = m_next; pend.push_back(m_next); m_next = m_next + 16'd1;
                end
                m_h = m_h | dh;
            end
            chk($sformatf("rnd%0d_rd_en", c), bus0.imem_rd_en, erd);
            if (erd) chk($sformatf("rnd%0d_addr", c), bus0.imem_addr, ea);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_valid", c), bus0.bundle_valid, m_v);
            if (m_v) begin
                chk($sformatf("rnd%0d_pc", c), bus0.bundle_pc, m_pc);
                chk($sformatf("rnd%0d_A0", c), bus0.A0, exp_a0(m_pc));
            end
            chk($sformatf("rnd%0d_halted", c), bus0.halted, m_h);
            $display("rnd %0d: stall=%0b pred=%0b tgt=%h valid=%0b pc=%h halted=%0b",
                     c, st, pr, tg, bus0.bundle_valid, bus0.bundle_pc, bus0.halted);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_bundle_unit.md
Name: fetch_bundle_unit

Overview:
Instruction-fetch stage for the DSP VLIW CPU. It generates bundle addresses for the synchronous instruction memory and captures each returned 88-bit bundle. It presents the four 22-bit slot instructions (A0, A1, M, LS) to instruction decode through the IF/ID register. It also handles decode stalls with a one-entry skid buffer, redirects on the decode-stage jump mispredict signal (predRW), and stops fetching on a HALT bundle.

Parameters:
PC_W, 16, bundle address width (one address = one bundle)
INSTR_W, 22, slot instruction width
RESET_PC, 16'h0000, first bundle address after reset
HALT_OP, 5'b11111, A0 opcode (bits [4:0]) that halts fetch
NOP_INSTR, 22'h000000, slot encoding injected on flush/bubble (opcode 0, cond bits [21:20]=0)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall  in  1  decode hazard stall; IF/ID must hold
predRW  in  1  jump mispredict from decode; redirect fetch
jmp_target  in  PC_W  redirect bundle address, valid when predRW=1
imem_addr  out  PC_W  instruction memory address
imem_rd_en  out  1  instruction memory read strobe
imem_data  in  4*INSTR_W  bundle {A0,A1,M,LS}, valid the cycle after the read strobe
A0, A1, M, LS  out  INSTR_W each  IF/ID slot instructions to decode
bundle_valid  out  1  IF/ID holds a real bundle
bundle_pc  out  PC_W  address of the bundle in IF/ID
halted  out  1  fetch stopped by HALT

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetch_pc=RESET_PC; inflight_v=0; skid_v=0; halted=0.
  - A0/A1/M/LS=NOP_INSTR; bundle_valid=0; bundle_pc=0.
  - rst mid-operation discards all state, including any in-flight read.
- Internal state: fetch_pc, inflight_v (a read was issued last cycle and not squashed), skid register plus skid_v, halted.
- Memory timing:
  - imem_addr/imem_rd_en are combinational from state and inputs.
  - imem_data for the address strobed at edge t is valid during cycle t+1.
  - No backpressure from memory.
- Source select: skid if skid_v, else imem_data if inflight_v, else none.
- Priority 1, predRW=1 (overrides stall and halted):
  - imem_addr=jmp_target; imem_rd_en=1; fetch_pc<=jmp_target+1; inflight_v<=1.
  - skid_v<=0; halted<=0.
  - IF/ID<=NOP, bundle_valid<=0.
  - The imem_data returning this cycle is discarded.
  - The target bundle reaches IF/ID two edges after the redirect edge, giving a 1-bubble penalty.
- Priority 2, stall=1:
  - IF/ID holds; imem_rd_en=0; fetch_pc holds; inflight_v<=0.
  - If inflight_v=1 and skid_v=0: skid<=imem_data, skid_v<=1.
  - With skid_v=1, no read can be in flight, so no overflow is possible.
- Priority 3, run (stall=0, predRW=0):
  - IF/ID<=source with bundle_valid<=1 and bundle_pc=that bundle's address; with no source, IF/ID<=NOP and bundle_valid<=0.
  - skid_v<=0.
  - If halted=0 and the bundle being loaded does not have A0[4:0]==HALT_OP: imem_addr=fetch_pc, imem_rd_en=1, fetch_pc<=fetch_pc+1, inflight_v<=1.
  - Else imem_rd_en=0, inflight_v<=0.
- HALT handling:
  - A bundle loaded with A0[4:0]==HALT_OP sets halted<=1. It is still delivered valid.
  - Reads already in flight still drain into IF/ID.
  - Only predRW or rst clears halted.
- fetch_pc arithmetic is modulo 2^PC_W; 16'hFFFF+1 wraps to 0.
- Each skid and in-flight entry tracks its own PC (entry address = fetch_pc-1 at issue time) so bundle_pc is exact.
- Throughput: 1 bundle/cycle steady state. The first valid bundle appears 2 edges after reset release.

Decomposition:
- Shared package cpu_pkg:
  - PC_W, INSTR_W, BUNDLE_W=4*INSTR_W
  - slot field offsets: opcode [4:0], R0 [9:5], R1 [14:10], Rd [19:15], cond [21:20]
  - opcode constants: JMP=5'b01001, HALT_OP
  - NOP_INSTR
- Sub-module fetch_skid_buf: holds the 1-entry {bundle, pc, valid} skid register with load/clear.

Test Plan:
1. Reset release, no stall, memory holds bundles 0..7 → imem_addr 0,1,2… on consecutive cycles; bundle_valid rises 2 edges after reset release with bundle_pc=0, then increments by 1 each cycle.
2. Stall asserted for 3 cycles while bundle_pc=3 → IF/ID holds bundle 3; the bundle 4 read in flight is captured in skid; imem_rd_en=0 during the stall. On release, IF/ID shows 4 then 5 with no gaps or duplicates.
3. predRW=1 with jmp_target=16'h0040 while bundle_pc=5 → next edge bundle_valid=0. The following edge loads bundle_pc=16'h0040. Bundles 6/7 never appear.
4. predRW and stall asserted together, skid full → redirect wins; skid cleared; target bundle delivered as in scenario 3.
5. Bundle at address 9 has A0[4:0]=5'b11111 → bundle 9 delivered valid; halted=1; no further imem_rd_en. A subsequent predRW to 16'h0002 clears halted and fetches 2,3,….
6. RESET_PC=16'hFFFE → bundle_pc sequence FFFE, FFFF, 0000, 0001. Asserting rst mid-stream returns all outputs to reset values on the next edge.
